// File: rtl/led_blink_sched.sv
// led_blink_sched: shares a single board LED between N_REQ blink-job requesters.
// Each job is (on ticks, off ticks, repeat count). One job runs at a time.
// The ON and OFF phases are timed off a prescaled tick.
// Build option LED_SCHED_RR_EN:
//   - defined: round-robin arbitration, starting from requester 0 after reset.
//   - undefined (default): fixed priority, where the lowest index wins.
module led_blink_sched #(
    parameter int N_REQ    = 4,
    parameter int TICK_DIV = 25_000,
    parameter int LEN_W    = 16,
    parameter int CNT_W    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [N_REQ-1:0]       req_i,
    input  logic [N_REQ*LEN_W-1:0] on_len_i,
    input  logic [N_REQ*LEN_W-1:0] off_len_i,
    input  logic [N_REQ*CNT_W-1:0] count_i,
    output logic [N_REQ-1:0]       gnt_o,
    output logic [N_REQ-1:0]       done_o,
    output logic                   busy_o,
    output logic                   led_o
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int PRE_W = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLINK_MAX = '1;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic [LEN_W-1:0] phase_q, phase_d;
    logic [LEN_W-1:0] on_q, on_d, off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, blinks_q, blinks_d;
    logic [IDX_W-1:0] sel_q, sel_d;
    logic [N_REQ-1:0] gnt_q, gnt_d, done_q, done_d;
    logic             busy_q, busy_d, led_q, led_d;

    logic             tick;
    logic             win_vld;
    logic [IDX_W-1:0] win_idx;
    logic [LEN_W-1:0] win_on, win_off;
    logic [CNT_W-1:0] win_cnt, blinks_inc;

    assign tick       = (pre_q == PRE_MAX);
    assign blinks_inc = blinks_q + 1'b1;

`ifdef LED_SCHED_RR_EN
    logic [IDX_W-1:0] ptr_q, ptr_d;

    // Round-robin pick: the first requester found after the last granted one.
    // The loop scans downward and overwrites, so the closest candidate ends up as the winner.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N_REQ; i >= 1; i--) begin
            if (req_i[IDX_W'((int'(ptr_q) + i) % N_REQ)]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end
`else
    // Fixed-priority pick: the lowest requesting index wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_vld = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
    end
`endif

    // Job parameters of the winning requester; a zero length is treated as 1 tick.
    always_comb begin
        win_on  = on_len_i[int'(win_idx)*LEN_W +: LEN_W];
        win_off = off_len_i[int'(win_idx)*LEN_W +: LEN_W];
        win_cnt = count_i[int'(win_idx)*CNT_W +: CNT_W];
        if (win_on == '0)  win_on  = LEN_W'(1);
        if (win_off == '0) win_off = LEN_W'(1);
    end

    // Next-state logic: job FSM, phase timing and registered outputs.
    always_comb begin
        state_d  = state_q;
        pre_d    = tick ? '0 : pre_q + 1'b1;
        phase_d  = phase_q;
        on_d     = on_q;
        off_d    = off_q;
        cnt_d    = cnt_q;
        blinks_d = blinks_q;
        sel_d    = sel_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        busy_d   = busy_q;
        led_d    = led_q;
`ifdef LED_SCHED_RR_EN
        ptr_d    = ptr_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                gnt_d  = '0;
                busy_d = 1'b0;
                led_d  = 1'b0;
                if (win_vld) begin
                    state_d  = S_ON;
                    sel_d    = win_idx;
                    on_d     = win_on;
                    off_d    = win_off;
                    cnt_d    = win_cnt;
                    blinks_d = '0;
                    pre_d    = '0;
                    phase_d  = '0;
                    gnt_d    = N_REQ'(1) << win_idx;
                    busy_d   = 1'b1;
                    led_d    = 1'b1;
`ifdef LED_SCHED_RR_EN
                    ptr_d    = win_idx;
`endif
                end
            end
            S_ON: begin
                if (!req_i[sel_q]) begin
                    // Abort: the requester withdrew, so no done pulse is raised.
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    led_d   = 1'b0;
                end else if (tick) begin
                    if (phase_q == on_q - 1'b1) begin
                        state_d = S_OFF;
                        phase_d = '0;
                        led_d   = 1'b0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_OFF: begin
                if (!req_i[sel_q]) begin
                    state_d = S_IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    led_d   = 1'b0;
                end else if (tick) begin
                    if (phase_q == off_q - 1'b1) begin
                        phase_d = '0;
                        // Saturate so an endless job never wraps around into a false match.
                        blinks_d = (blinks_q == BLINK_MAX) ? blinks_q : blinks_inc;
                        if (cnt_q != '0 && blinks_inc == cnt_q) begin
                            state_d = S_DONE;
                            done_d  = gnt_q;
                            gnt_d   = '0;
                            busy_d  = 1'b0;
                            led_d   = 1'b0;
                        end else begin
                            state_d = S_ON;
                            led_d   = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            S_DONE: begin
                // Hold one idle cycle before arbitrating again.
                state_d = S_IDLE;
                gnt_d   = '0;
                busy_d  = 1'b0;
                led_d   = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            pre_q    <= '0;
            phase_q  <= '0;
            on_q     <= '0;
            off_q    <= '0;
            cnt_q    <= '0;
            blinks_q <= '0;
            sel_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
            led_q    <= 1'b0;
`ifdef LED_SCHED_RR_EN
            ptr_q    <= IDX_W'(N_REQ - 1);
`endif
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            phase_q  <= phase_d;
            on_q     <= on_d;
            off_q    <= off_d;
            cnt_q    <= cnt_d;
            blinks_q <= blinks_d;
            sel_q    <= sel_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            led_q    <= led_d;
`ifdef LED_SCHED_RR_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    assign gnt_o  = gnt_q;
    assign done_o = done_q;
    assign busy_o = busy_q;
    assign led_o  = led_q;

endmodule

// File: tb/tb_led_blink_sched.sv
// Bench for led_blink_sched (N_REQ=4, TICK_DIV=4).
// The reference model describes each job as a timeline measured in cycles since its grant.
// It is checked every cycle and is supported by literal timing checks.
module tb_led_blink_sched;
    localparam int N  = 4;
    localparam int TD = 4;
    localparam int LW = 16;
    localparam int CW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N*LW-1:0] on_len = '0;
    logic [N*LW-1:0] off_len = '0;
    logic [N*CW-1:0] count = '0;
    logic [N-1:0]    gnt, done;
    logic            busy, led;

    int n_checks = 0;
    int n_fail   = 0;

    led_blink_sched #(.N_REQ(N), .TICK_DIV(TD), .LEN_W(LW), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .req_i(req), .on_len_i(on_len),
        .off_len_i(off_len), .count_i(count), .gnt_o(gnt), .done_o(done),
        .busy_o(busy), .led_o(led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic m_act, m_done;
    int   m_k, m_el, m_on, m_off, m_cnt, m_win, m_wi;

    function automatic int eff(input int v);
        return (v == 0) ? 1 : v;
    endfunction

`ifdef LED_SCHED_RR_EN
    int m_ptr;
    function automatic int pick(input logic [N-1:0] r, input int ptr);
        pick = -1;
        for (int i = 1; i <= N; i++)
            if (pick < 0 && r[(ptr + i) % N]) pick = (ptr + i) % N;
    endfunction
    assign m_win = pick(req, m_ptr);
`else
    function automatic int pick(input logic [N-1:0] r);
        pick = -1;
        for (int i = 0; i < N; i++)
            if (pick < 0 && r[i]) pick = i;
    endfunction
    assign m_win = pick(req);
`endif
    assign m_wi = (m_win < 0) ? 0 : m_win;

    // The job's elapsed-cycle count advances at each edge.
    // The job finishes after count*(on+off)*TD cycles, or ends early when its request drops.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_act <= 1'b0; m_done <= 1'b0; m_k <= 0; m_el <= 0;
            m_on <= 1; m_off <= 1; m_cnt <= 0;
`ifdef LED_SCHED_RR_EN
            m_ptr <= N - 1;
`endif
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_act) begin
            if (!req[m_k]) m_act <= 1'b0;
            else if (m_cnt != 0 && m_el + 1 == m_cnt * (m_on + m_off) * TD) begin
                m_act  <= 1'b0;
                m_done <= 1'b1;
            end else m_el <= m_el + 1;
        end else if (m_win >= 0) begin
            m_act <= 1'b1;
            m_k   <= m_wi;
            m_el  <= 0;
            m_on  <= eff(int'(on_len[m_wi*LW +: LW]));
            m_off <= eff(int'(off_len[m_wi*LW +: LW]));
            m_cnt <= int'(count[m_wi*CW +: CW]);
`ifdef LED_SCHED_RR_EN
            m_ptr <= m_wi;
`endif
        end
    end

    logic [N-1:0] e_gnt, e_done;
    logic         e_busy, e_led;
    assign e_gnt  = m_act ? (N'(1) << m_k) : '0;
    assign e_done = m_done ? (N'(1) << m_k) : '0;
    assign e_busy = m_act;
    assign e_led  = m_act && ((m_el % ((m_on + m_off) * TD)) < m_on * TD);

    always @(negedge clk) begin
        check("m_gnt",  32'(gnt),  32'(e_gnt));
        check("m_done", 32'(done), 32'(e_done));
        check("m_busy", 32'(busy), 32'(e_busy));
        check("m_led",  32'(led),  32'(e_led));
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive_slot();  // step to just after a rising edge
        @(posedge clk); #2;
    endtask

    task automatic set_job(input int k, input int on, input int off, input int cnt);
        on_len[k*LW +: LW]  = LW'(on);
        off_len[k*LW +: LW] = LW'(off);
        count[k*CW +: CW]   = CW'(cnt);
    endtask

    task automatic run_len(input logic lvl, output int n);
        n = 0;
        while (led === lvl && done == '0 && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_gnt(input string name);
        int c = 0;
        while (gnt == '0 && c < 100) begin c++; @(negedge clk); end
        check({name, "_gnt_timeout"}, 32'(gnt != '0), 32'd1);
    endtask

    task automatic wait_done(input string name, input logic [N-1:0] exp);
        int c = 0;
        while (done == '0 && c < 500) begin c++; @(negedge clk); end
        check({name, "_done"}, 32'(done), 32'(exp));
    endtask

    initial begin
        int n;
        logic seen;
        // Reset state
        #12;
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_led", 32'(led), 32'd0);
        drive_slot(); rst_n = 1'b1;

        // Test 1: on=2, off=3, count=2
        drive_slot(); set_job(0, 2, 3, 2); req = 4'b0001;
        @(negedge clk); check("t1_gnt_pre", 32'(gnt), 32'd0);
        @(negedge clk); check("t1_gnt", 32'(gnt), 32'b0001);
        check("t1_busy", 32'(busy), 32'd1);
        run_len(1'b1, n); check("t1_on1", n, 8);
        run_len(1'b0, n); check("t1_off1", n, 12);
        run_len(1'b1, n); check("t1_on2", n, 8);
        run_len(1'b0, n); check("t1_off2", n, 12);
        check("t1_done", 32'(done), 32'b0001);
        check("t1_gnt_end", 32'(gnt), 32'd0);
        check("t1_busy_end", 32'(busy), 32'd0);
        @(negedge clk); check("t1_done_once", 32'(done), 32'd0);
        drive_slot(); req = '0;

        // Test 2: simultaneous requests 1 and 2
        drive_slot(); set_job(1, 1, 1, 1); set_job(2, 1, 1, 1); req = 4'b0110;
        @(negedge clk); @(negedge clk); check("t2_first", 32'(gnt), 32'b0010);
        wait_done("t2a", 4'b0010);
        drive_slot(); req[1] = 1'b0;
        @(negedge clk); @(negedge clk); check("t2_second", 32'(gnt), 32'b0100);
        wait_done("t2b", 4'b0100);
        drive_slot(); req = '0;

`ifdef LED_SCHED_RR_EN
        // Round-robin rotation after a fresh reset
        drive_slot(); rst_n = 1'b0;
        drive_slot(); rst_n = 1'b1;
        for (int k = 0; k < N; k++) set_job(k, 1, 1, 1);
        req = 4'b1111;
        begin
            logic [N-1:0] exp_seq [5];
            exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                wait_gnt("rr");
                check("rr_gnt", 32'(gnt), 32'(exp_seq[i]));
                wait_done("rr", exp_seq[i]);
            end
        end
        drive_slot(); req = '0;
`endif

        // Test 3: zero lengths are treated as 1 tick
        drive_slot(); set_job(0, 0, 0, 1); req = 4'b0001;
        @(negedge clk); wait_gnt("t3");
        run_len(1'b1, n); check("t3_on", n, 4);
        run_len(1'b0, n); check("t3_off", n, 4);
        check("t3_done", 32'(done), 32'b0001);
        drive_slot(); req = '0;

        // Test 4: infinite job aborted mid-ON
        drive_slot(); set_job(3, 2, 1, 0); req = 4'b1000;
        @(negedge clk); wait_gnt("t4");
        repeat (3) @(negedge clk);
        drive_slot(); req = '0;
        @(negedge clk); check("t4_led_hold", 32'(led), 32'd1);
        @(negedge clk);
        check("t4_gnt", 32'(gnt), 32'd0);
        check("t4_led", 32'(led), 32'd0);
        check("t4_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        repeat (30) begin @(negedge clk); if (done != '0) seen = 1'b1; end
        check("t4_no_done", 32'(seen), 32'd0);

        // Test 5: reset pulse during OFF, then a fresh full ON phase
        drive_slot(); set_job(0, 2, 3, 1); req = 4'b0001;
        @(negedge clk); wait_gnt("t5");
        run_len(1'b1, n); check("t5_on", n, 8);
        drive_slot(); rst_n = 1'b0;
        #1;
        check("t5_rst_gnt", 32'(gnt), 32'd0);
        check("t5_rst_busy", 32'(busy), 32'd0);
        check("t5_rst_led", 32'(led), 32'd0);
        drive_slot(); rst_n = 1'b1;
        @(negedge clk); wait_gnt("t5r");
        run_len(1'b1, n); check("t5_on_restart", n, 8);
        wait_done("t5", 4'b0001);
        drive_slot(); req = '0;

        // Test 6: on_len changed while granted is ignored
        drive_slot(); set_job(2, 3, 1, 1); req = 4'b0100;
        @(negedge clk); wait_gnt("t6");
        drive_slot(); set_job(2, 7, 5, 3);
        @(negedge clk);
        run_len(1'b1, n); check("t6_on", n, 11);
        run_len(1'b0, n); check("t6_off", n, 4);
        check("t6_done", 32'(done), 32'b0100);
        drive_slot(); req = '0;

        // More than 2^CNT_W blinks in infinite mode: no spurious done
        drive_slot(); set_job(1, 0, 0, 0); req = 4'b0010;
        seen = 1'b0;
        repeat (2100) begin @(negedge clk); if (done != '0) seen = 1'b1; end
        check("sat_no_done", 32'(seen), 32'd0);
        check("sat_busy", 32'(busy), 32'd1);
        drive_slot(); req = '0;

        // Randomized traffic checked by the model
        repeat (3000) begin
            drive_slot();
            for (int k = 0; k < N; k++) begin
                if (!req[k]) begin
                    if ($urandom_range(7) == 0) begin
                        set_job(k, $urandom_range(3), $urandom_range(3), $urandom_range(3));
                        req[k] = 1'b1;
                    end
                end else if (done[k]) begin
                    if ($urandom_range(3) != 0) req[k] = 1'b0;
                end else if ($urandom_range(63) == 0) begin
                    req[k] = 1'b0;
                end
            end
            if ($urandom_range(15) == 0)
                set_job($urandom_range(N - 1), $urandom_range(3), $urandom_range(3), $urandom_range(3));
        end
        drive_slot(); req = '0;
        repeat (20) @(negedge clk);
        check("end_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
